move_cmd_gen: RTL and testbench
===============================

MOVE_CMD_GEN -- requirements
Module: move_cmd_gen

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50_000, giving the number of stable cycles required before a debounced input changes.
REQ-002 The block SHALL have parameter REFRESH_CYCLES, default 5_000_000, giving the interval between periodic re-sends.
REQ-003 The block SHALL have parameter RAMP_CYCLES, default 2_500_000, giving the dwell time per ramp step.
REQ-004 The block SHALL have parameter SPEED_INIT, default 5, giving the reset speed.
REQ-005 The block SHALL have parameter SPEED_MAX, default 9, giving the saturation speed.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have ports key_w, key_a, key_s, key_d, input, 1 bit each: raw asynchronous drive keys, active-high.
REQ-009 The block SHALL have ports spd_up and spd_dn, input, 1 bit each: raw asynchronous speed buttons, active-high.
REQ-010 The block SHALL have port ready, input, 1 bit: downstream UART command sender is able to accept a command.
REQ-011 The block SHALL have port move_cmd, output, 4 bits: movement code.
REQ-012 The block SHALL have port speed_level, output, 4 bits: speed value, 0..SPEED_MAX.
REQ-013 The block SHALL have port valid, output, 1 bit: a new or refreshed command is pending.

Function
REQ-014 Each of the six raw inputs SHALL pass through a 2-FF synchronizer, then a per-input debounce counter; the debounced value SHALL update only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 The debounce counter SHALL clear on any cycle where the synchronized value equals the debounced value.
REQ-016 Debounced keys SHALL map to move_cmd as follows:
- w=0
- w+a=1
- w+d=2
- s=3
- a=4
- d=5
- s+a=6
- s+d=7
REQ-017 Any other key combination SHALL map to move_cmd 8 (stop); this covers no keys, w+s, a+d, and three or more keys.
REQ-018 A rising edge of debounced spd_up SHALL increment the target speed, saturating at SPEED_MAX.
REQ-019 A rising edge of debounced spd_dn SHALL decrement the target speed, saturating at 0.
REQ-020 Rising edges of spd_up and spd_dn in the same cycle SHALL leave the target speed unchanged.
REQ-021 move_cmd and speed_level SHALL be registered outputs, updated one cycle after the decoded or target value changes.
REQ-022 The handshake SHALL use two states, IDLE and PEND.
REQ-023 In IDLE, a change of move_cmd or speed_level, or expiry of the refresh counter, SHALL move the block to PEND with valid=1 from the next cycle.
REQ-024 In PEND, valid SHALL stay high until a cycle with ready=1; the block SHALL then return to IDLE with valid=0 on the following cycle.
REQ-025 When ready is already high on entry to PEND, valid SHALL still be high for at least one cycle.
REQ-026 An output change during PEND SHALL update move_cmd and speed_level in place, keep valid high, and not restart the state.
REQ-027 The refresh counter SHALL count cycles in IDLE, clear on every entry to PEND, and expire when it reaches REFRESH_CYCLES-1.
REQ-028 The refresh counter SHALL wrap to 0 on expiry.
REQ-029 Counter widths SHALL be $clog2 of the respective parameter; speed arithmetic SHALL be 4-bit unsigned with saturation, never modulo.

Reset
REQ-030 On rst=1 at a clock edge, the outputs SHALL take move_cmd=8, speed_level=SPEED_INIT and valid=0.
REQ-031 On rst=1 at a clock edge, the state SHALL become IDLE, all counters SHALL clear, the target speed SHALL become SPEED_INIT, and the synchronizer and debounced values SHALL become 0.
REQ-032 Reset asserted during PEND SHALL abandon the pending command; no valid pulse SHALL follow the release of reset unless the inputs change or the refresh counter expires.

Configuration
REQ-033 With macro MOVE_CMD_RAMP_EN defined, speed_level on any transition from move_cmd 8 to a non-stop code SHALL restart at 1 (or 0 when the target speed is 0).
REQ-034 With MOVE_CMD_RAMP_EN defined, speed_level SHALL then rise by 1 every RAMP_CYCLES cycles until it equals the target speed.
REQ-035 With MOVE_CMD_RAMP_EN defined, a decrease of the target speed SHALL apply immediately, each ramp step SHALL count as an output change, and the stop code SHALL force no ramp.
REQ-036 Without MOVE_CMD_RAMP_EN, speed_level SHALL equal the target speed at all times except the one-cycle register latency, and the ramp counter SHALL be absent.

Verification
(All scenarios use DEBOUNCE_CYCLES=4, REFRESH_CYCLES=64, RAMP_CYCLES=8.)
REQ-037 Bench SHALL cover: key_w high for 10 cycles with ready=1 -> move_cmd 8->0 within 4+2+1 cycles of the input edge, valid high for exactly 1 cycle.
REQ-038 Bench SHALL cover: key_a pulsed high for 2 cycles (glitch) -> move_cmd stays 8, no valid.
REQ-039 Bench SHALL cover: key_w+key_s both held -> move_cmd 8; after adding key_a (three keys) -> move_cmd still 8; after releasing key_s -> move_cmd 1 with one valid.
REQ-040 Bench SHALL cover: 6 spd_up presses from reset -> speed_level 9 after the 4th press, 9 after presses 5 and 6; then 10 spd_dn presses -> speed_level 0 with no underflow.
REQ-041 Bench SHALL cover: ready=0, key_d held, then spd_up -> valid held high with move_cmd=5 and speed_level=6 updated in place; ready=1 -> valid falls on the next cycle.
REQ-042 Bench SHALL cover: idle with ready=1 -> valid pulses every 64 cycles. With MOVE_CMD_RAMP_EN and key_w from stop at target 5 -> speed_level 1,2,3,4,5 at 8-cycle steps, one valid per step.

Source files
------------

// File: rtl/move_cmd_gen.sv
// move_cmd_gen: debounced WASD/speed keys to movement code + speed with a valid/ready refresh handshake.
// Optional build macro MOVE_CMD_RAMP_EN: speed ramps up from 1 whenever motion starts from stop.
module move_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter int REFRESH_CYCLES  = 5_000_000,
    parameter int RAMP_CYCLES     = 2_500_000,
    parameter int SPEED_INIT      = 5,
    parameter int SPEED_MAX       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_w,
    input  logic       key_a,
    input  logic       key_s,
    input  logic       key_d,
    input  logic       spd_up,
    input  logic       spd_dn,
    input  logic       ready,
    output logic [3:0] move_cmd,
    output logic [3:0] speed_level,
    output logic       valid
);
    localparam logic [3:0] STOP = 4'd8;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int FW = $clog2(REFRESH_CYCLES);

    typedef enum logic {IDLE, PEND} state_t;

    logic [5:0]    w_raw;
    logic [5:0]    r_sync1, r_sync2, r_deb;
    logic [DW-1:0] r_db_cnt [6];
    logic          r_up_q, r_dn_q, w_up, w_dn;
    logic [3:0]    r_target, w_cmd, w_speed_nxt, r_move, r_speed;
    logic [FW-1:0] r_rf_cnt, w_rf_inc, w_rf_nxt;
    logic          w_expire, w_chg;
    state_t        r_state, w_state_nxt;

    assign w_raw = {spd_dn, spd_up, key_d, key_s, key_a, key_w};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < 6; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 6; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Key bits ordered {w, a, s, d}; anything not listed is stop.
    always_comb begin
        w_cmd = STOP;
        case (r_deb[3:0] == 4'b0 ? 4'b0 : {r_deb[0], r_deb[1], r_deb[2], r_deb[3]})
            4'b1000: w_cmd = 4'd0;
            4'b1100: w_cmd = 4'd1;
            4'b1001: w_cmd = 4'd2;
            4'b0010: w_cmd = 4'd3;
            4'b0100: w_cmd = 4'd4;
            4'b0001: w_cmd = 4'd5;
            4'b0110: w_cmd = 4'd6;
            4'b0011: w_cmd = 4'd7;
            default: w_cmd = STOP;
        endcase
    end

    assign w_up = r_deb[4] & ~r_up_q;
    assign w_dn = r_deb[5] & ~r_dn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_q   <= 1'b0;
            r_dn_q   <= 1'b0;
            r_target <= 4'(SPEED_INIT);
        end else begin
            r_up_q <= r_deb[4];
            r_dn_q <= r_deb[5];
            if (w_up && !w_dn && r_target < 4'(SPEED_MAX))
                r_target <= r_target + 4'd1;
            else if (w_dn && !w_up && r_target != 4'd0)
                r_target <= r_target - 4'd1;
        end
    end

`ifdef MOVE_CMD_RAMP_EN
    localparam int RW = $clog2(RAMP_CYCLES);
    logic [RW-1:0] r_ramp_cnt;
    logic          w_ramp_step, w_start;

    assign w_start     = (w_cmd != STOP) && (r_move == STOP);
    assign w_ramp_step = (r_ramp_cnt == RW'(RAMP_CYCLES - 1));

    // Decreases and the stop code snap straight to the target; only rises are paced.
    always_comb begin
        w_speed_nxt = r_target;
        if (w_start)
            w_speed_nxt = (r_target == 4'd0) ? 4'd0 : 4'd1;
        else if (w_cmd != STOP && r_speed < r_target)
            w_speed_nxt = w_ramp_step ? r_speed + 4'd1 : r_speed;
    end

    always_ff @(posedge clk) begin
        if (rst || w_cmd == STOP || w_start || r_speed >= r_target || w_ramp_step)
            r_ramp_cnt <= '0;
        else
            r_ramp_cnt <= r_ramp_cnt + 1'b1;
    end
`else
    assign w_speed_nxt = r_target;
`endif

    assign w_chg    = (w_cmd != r_move) || (w_speed_nxt != r_speed);
    assign w_rf_inc = r_rf_cnt + 1'b1;
    assign w_expire = (w_rf_inc == FW'(REFRESH_CYCLES - 1));

    // A change arriving in the same cycle as ready keeps the command pending.
    always_comb begin
        w_state_nxt = r_state;
        w_rf_nxt    = r_rf_cnt;
        if (r_state == IDLE) begin
            w_state_nxt = (w_chg || w_expire) ? PEND : IDLE;
            w_rf_nxt    = (w_chg || w_expire) ? '0 : w_rf_inc;
        end else begin
            w_state_nxt = (ready && !w_chg) ? IDLE : PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rf_cnt <= '0;
            r_move   <= STOP;
            r_speed  <= 4'(SPEED_INIT);
        end else begin
            r_state  <= w_state_nxt;
            r_rf_cnt <= w_rf_nxt;
            r_move   <= w_cmd;
            r_speed  <= w_speed_nxt;
        end
    end

    assign move_cmd    = r_move;
    assign speed_level = r_speed;
    assign valid       = (r_state == PEND);
endmodule

// File: tb/tb_move_cmd_gen.sv
// tb_move_cmd_gen: directed scenarios for move_cmd_gen with short debounce/refresh/ramp periods.
module tb_move_cmd_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_w = 1'b0, key_a = 1'b0, key_s = 1'b0, key_d = 1'b0;
    logic       spd_up = 1'b0, spd_dn = 1'b0, ready = 1'b1;
    logic [3:0] move_cmd, speed_level;
    logic       valid;
    int         checks = 0;
    int         failures = 0;
    int         vcnt = 0;

`ifdef MOVE_CMD_RAMP_EN
    localparam int PEND_SPEED = 2;
`else
    localparam int PEND_SPEED = 6;
`endif

    move_cmd_gen #(
        .DEBOUNCE_CYCLES(4),
        .REFRESH_CYCLES(64),
        .RAMP_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .key_w(key_w), .key_a(key_a), .key_s(key_s), .key_d(key_d),
        .spd_up(spd_up), .spd_dn(spd_dn), .ready(ready),
        .move_cmd(move_cmd), .speed_level(speed_level), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid) vcnt++;
        end
    endtask

    task automatic do_reset();
        {key_w, key_a, key_s, key_d, spd_up, spd_dn} = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vcnt = 0;
    endtask

    task automatic test_reset();
        ready = 1'b1;
        do_reset();
        checks++; if (move_cmd !== 4'd8) begin failures++; $display("FAIL reset_move got=%0d exp=8", move_cmd); end
        checks++; if (speed_level !== 4'd5) begin failures++; $display("FAIL reset_speed got=%0d exp=5", speed_level); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    endtask

    task automatic test_single_key();
        int lat = 0;
        logic vat = 1'b0;
        ready = 1'b1;
        do_reset();
        key_w = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (valid) vcnt++;
            if (move_cmd === 4'd0 && lat == 0) begin lat = i; vat = valid; end
        end
        checks++; if (lat != 7) begin failures++; $display("FAIL key_w_latency got=%0d exp=7", lat); end
        checks++; if (vat !== 1'b1) begin failures++; $display("FAIL key_w_valid_at_change got=%0b exp=1", vat); end
        checks++; if (vcnt != 1) begin failures++; $display("FAIL key_w_valid_cycles got=%0d exp=1", vcnt); end
        key_w = 1'b0;
        run(10);
        checks++; if (move_cmd !== 4'd8) begin failures++; $display("FAIL key_w_release got=%0d exp=8", move_cmd); end
    endtask

    task automatic test_glitch();
        ready = 1'b1;
        do_reset();
        key_a = 1'b1;
        run(2);
        key_a = 1'b0;
        run(12);
        checks++; if (move_cmd !== 4'd8) begin failures++; $display("FAIL glitch_move got=%0d exp=8", move_cmd); end
        checks++; if (vcnt != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", vcnt); end
    endtask

    task automatic test_combo();
        ready = 1'b1;
        do_reset();
        key_w = 1'b1; key_s = 1'b1;
        run(10);
        checks++; if (move_cmd !== 4'd8) begin failures++; $display("FAIL ws_move got=%0d exp=8", move_cmd); end
        checks++; if (vcnt != 0) begin failures++; $display("FAIL ws_valid got=%0d exp=0", vcnt); end
        key_a = 1'b1;
        run(10);
        checks++; if (move_cmd !== 4'd8) begin failures++; $display("FAIL wsa_move got=%0d exp=8", move_cmd); end
        checks++; if (vcnt != 0) begin failures++; $display("FAIL wsa_valid got=%0d exp=0", vcnt); end
        key_s = 1'b0;
        run(10);
        checks++; if (move_cmd !== 4'd1) begin failures++; $display("FAIL wa_move got=%0d exp=1", move_cmd); end
        checks++; if (vcnt != 1) begin failures++; $display("FAIL wa_valid got=%0d exp=1", vcnt); end
    endtask

    task automatic press(input logic up, input logic dn);
        spd_up = up; spd_dn = dn;
        run(8);
        spd_up = 1'b0; spd_dn = 1'b0;
        run(8);
    endtask

    task automatic test_speed();
        int exp_up [6] = '{6, 7, 8, 9, 9, 9};
        int exp_dn [10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
        ready = 1'b1;
        do_reset();
        press(1'b1, 1'b1);
        checks++; if (speed_level !== 4'd5) begin failures++; $display("FAIL both_press got=%0d exp=5", speed_level); end
        for (int k = 0; k < 6; k++) begin
            press(1'b1, 1'b0);
            checks++; if (speed_level !== 4'(exp_up[k])) begin failures++; $display("FAIL up_press%0d got=%0d exp=%0d", k + 1, speed_level, exp_up[k]); end
        end
        for (int k = 0; k < 10; k++) begin
            press(1'b0, 1'b1);
            checks++; if (speed_level !== 4'(exp_dn[k])) begin failures++; $display("FAIL dn_press%0d got=%0d exp=%0d", k + 1, speed_level, exp_dn[k]); end
        end
    endtask

    task automatic test_pend_in_place();
        ready = 1'b0;
        do_reset();
        key_d = 1'b1;
        run(10);
        checks++; if (move_cmd !== 4'd5 || valid !== 1'b1) begin failures++; $display("FAIL pend_d got=%0d/%0b exp=5/1", move_cmd, valid); end
        spd_up = 1'b1;
        run(10);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL pend_valid_held got=%0b exp=1", valid); end
        checks++; if (speed_level !== 4'(PEND_SPEED)) begin failures++; $display("FAIL pend_speed got=%0d exp=%0d", speed_level, PEND_SPEED); end
        spd_up = 1'b0;
        run(8);
        checks++; if (move_cmd !== 4'd5 || valid !== 1'b1) begin failures++; $display("FAIL pend_before_ready got=%0d/%0b exp=5/1", move_cmd, valid); end
        ready = 1'b1;
        tick();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL pend_ready_drop got=%0b exp=0", valid); end
        key_d = 1'b0;
        run(10);
    endtask

    task automatic test_reset_pend();
        ready = 1'b0;
        do_reset();
        key_w = 1'b1;
        run(10);
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL rstpend_pre got=%0b exp=1", valid); end
        key_w = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (valid !== 1'b0 || move_cmd !== 4'd8) begin failures++; $display("FAIL rstpend_reset got=%0b/%0d exp=0/8", valid, move_cmd); end
        vcnt = 0;
        run(30);
        checks++; if (vcnt != 0) begin failures++; $display("FAIL rstpend_no_valid got=%0d exp=0", vcnt); end
    endtask

    task automatic test_refresh();
        int t1 = 0, t2 = 0;
        ready = 1'b1;
        do_reset();
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (valid && t1 == 0) t1 = i;
            else if (valid && t2 == 0) t2 = i;
        end
        checks++; if (t1 != 63) begin failures++; $display("FAIL refresh_first got=%0d exp=63", t1); end
        checks++; if (t2 - t1 != 64) begin failures++; $display("FAIL refresh_period got=%0d exp=64", t2 - t1); end
    endtask

`ifdef MOVE_CMD_RAMP_EN
    task automatic test_ramp();
        ready = 1'b1;
        do_reset();
        key_w = 1'b1;
        run(7);
        checks++; if (move_cmd !== 4'd0 || speed_level !== 4'd1 || valid !== 1'b1) begin failures++; $display("FAIL ramp_start got=%0d/%0d/%0b exp=0/1/1", move_cmd, speed_level, valid); end
        vcnt = 0;
        for (int k = 2; k <= 5; k++) begin
            run(8);
            checks++; if (speed_level !== 4'(k) || valid !== 1'b1) begin failures++; $display("FAIL ramp_step got=%0d/%0b exp=%0d/1", speed_level, valid, k); end
        end
        checks++; if (vcnt != 4) begin failures++; $display("FAIL ramp_valids got=%0d exp=4", vcnt); end
        run(20);
        checks++; if (speed_level !== 4'd5) begin failures++; $display("FAIL ramp_hold got=%0d exp=5", speed_level); end
        key_w = 1'b0;
        run(10);
    endtask
`endif

    initial begin
        test_reset();
        test_single_key();
        test_glitch();
        test_combo();
        test_speed();
        test_pend_in_place();
        test_reset_pend();
        test_refresh();
`ifdef MOVE_CMD_RAMP_EN
        test_ramp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
